mem_bus_master: RTL

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_pkg.sv | 43 ++++
 rtl/mem_lane_mux.sv | 54 +++++
 rtl/mem_bus_master.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and lane constants for the memory bus master
package mem_bus_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int DATA_W = LANES * LANE_W;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } bus_state_t;

    function automatic logic op_is_load(input mem_op_t op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            LH, LHU, SH: mis = addr_lo[0];
            LW, SW:      mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// rtl/mem_lane_mux.sv - byteenable/writedata generation and load extraction
module mem_lane_mux
    import mem_bus_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    // Lower address sits on the lower lane but carries the more significant CPU byte.
    always_comb begin
        mem_op_t     o;
        logic [31:0] mask;
        logic [31:0] shifted;
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [31:0] word_sel;

        o        = mem_op_t'(op);
        shifted  = rdata >> {addr_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo[1] ? {rdata[23:16], rdata[31:24]} : {rdata[7:0], rdata[15:8]};
        word_sel = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};

        case (o)
            LB, LBU, SB: be = 4'b0001 << addr_lo;
            LH, LHU, SH: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase

        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

        case (o)
            SB:      bus_wdata = {4{wdata[7:0]}} & mask;
            SH:      bus_wdata = {2{wdata[7:0], wdata[15:8]}} & mask;
            SW:      bus_wdata = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
            default: bus_wdata = 32'd0;
        endcase

        case (o)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_data = {24'd0, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LHU:     load_data = {16'd0, half_sel};
            LW:      load_data = word_sel;
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - CPU load/store to Avalon-MM master; MEM_BUS_MASTER_TIMEOUT_EN adds a waitrequest watchdog
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [1:0] RL = 2'(READ_LATENCY);

    bus_state_t  state;
    logic [2:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  rd_cnt;

    logic [2:0]  mux_op;
    logic [1:0]  mux_addr_lo;
    logic [3:0]  mux_be;
    logic [31:0] mux_wdata;
    logic [31:0] mux_load;

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] wd_cnt;
`endif

    // Ready is visible only out of reset and only while idle.
    assign req_ready = reset_n && (state == IDLE);

    // The lane mux sees the live request while idle and the latched one afterwards.
    assign mux_op      = (state == IDLE) ? req_op        : op_q;
    assign mux_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;

    mem_lane_mux u_lane_mux (
        .op        (mux_op),
        .addr_lo   (mux_addr_lo),
        .wdata     (req_wdata),
        .rdata     (avm_readdata),
        .be        (mux_be),
        .bus_wdata (mux_wdata),
        .load_data (mux_load)
    );

    // Transaction FSM; all outputs are registered and the command is held until accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            op_q           <= 3'd0;
            addr_lo_q      <= 2'd0;
            rd_cnt         <= 2'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_err       <= 1'b0;
            avm_address    <= 32'd0;
            avm_byteenable <= 4'd0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 32'd0;
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
            wd_cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        addr_lo_q <= req_addr[1:0];
                        if (op_misaligned(mem_op_t'(req_op), req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state          <= CMD;
                            avm_address    <= {req_addr[31:2], 2'b00};
                            avm_byteenable <= mux_be;
                            avm_writedata  <= mux_wdata;
                            avm_read       <= op_is_load(mem_op_t'(req_op));
                            avm_write      <= !op_is_load(mem_op_t'(req_op));
                        end
                    end
                end
                CMD: begin
                    if (!avm_waitrequest) begin
                        avm_read       <= 1'b0;
                        avm_write      <= 1'b0;
                        avm_address    <= 32'd0;
                        avm_byteenable <= 4'd0;
                        avm_writedata  <= 32'd0;
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
                        wd_cnt         <= '0;
`endif
                        if (op_is_load(mem_op_t'(op_q))) begin
                            state  <= RDWAIT;
                            rd_cnt <= 2'd1;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'd0;
                        end
                    end
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
                    else if (wd_cnt == TMO_LAST) begin
                        avm_read       <= 1'b0;
                        avm_write      <= 1'b0;
                        avm_address    <= 32'd0;
                        avm_byteenable <= 4'd0;
                        avm_writedata  <= 32'd0;
                        wd_cnt         <= '0;
                        state          <= RESP;
                        resp_valid     <= 1'b1;
                        resp_err       <= 1'b1;
                        resp_rdata     <= 32'd0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                RDWAIT: begin
                    if (rd_cnt == RL) begin
                        rd_cnt     <= 2'd0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= mux_load;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
